// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4 memory subordinate: burst and response
// encodings, the transaction state enum and the per-beat address step.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WB
  } state_t;

  // Address of the beat following addr. Beats are always 8 bytes wide.
  // WRAP is only honoured for 2/4/8/16-beat bursts; other lengths step as INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] inc;
    logic [31:0] mask;
    inc  = addr + 32'd8;
    // (len+1)*8-1 for the legal wrap lengths
    mask = {21'd0, len, 3'b111};
    next_addr = inc;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          next_addr = (addr & ~mask) | (inc & mask);
        else
          next_addr = inc;
      end
      default: next_addr = inc;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Synchronous single-port RAM, 64-bit words, one write enable per byte lane.
// Read data is registered and reflects the word addressed on the previous edge.
module axi_mem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               we,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] q_reg;

      // One byte lane: optional write, then registered read of the same word
      always_ff @(posedge clk) begin
        if (we[gi])
          lane_mem[addr] <= wdata[gi*8 +: 8];
        q_reg <= lane_mem[addr];
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 subordinate with an internal byte-writable memory. One read or write
// burst at a time; FIXED/INCR/WRAP bursts of full 64-bit beats.
// Optional build macro AXI_MEM_RANGE_CHECK_EN: beats outside the memory window
// are suppressed and answered with SLVERR; without it the index wraps.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int AW = $clog2(DEPTH);

  state_t      state_reg, state_next;
  logic        rr_pref_reg, rr_pref_next;   // 0: read wins the next conflict
  logic        arready_reg, arready_next;
  logic        awready_reg, awready_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  id_reg, id_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  beat_reg, beat_next;
  logic [1:0]  burst_reg, burst_next;
  logic        err_reg, err_next;
  logic        rvalid_reg, rvalid_next;
  logic        rlast_reg, rlast_next;
  logic        rerr_reg, rerr_next;

  logic [31:0] ram_byte_addr;
  logic [31:0] offset;
  logic [AW-1:0] ram_index;
  logic [7:0]  ram_we;
  logic [63:0] ram_q;
  logic        beat_in_range;
  logic        ar_hs, aw_hs, r_hs, w_hs;
  logic        unused_offset_bits;

  // Ready is only ever raised for the channel already chosen, so at most one
  // address handshake can happen per idle period.
  assign ar_hs = arvalid && arready_reg;
  assign aw_hs = awvalid && awready_reg;
  assign r_hs  = rvalid_reg && rready;
  assign w_hs  = (state_reg == ST_WR) && wvalid;

  // Pick the address the RAM sees this cycle; on a read handshake look ahead
  // to the next beat so its data is ready without a bubble.
  always_comb begin
    ram_byte_addr = addr_reg;
    if (state_reg == ST_IDLE)
      ram_byte_addr = araddr;
    else if (state_reg == ST_RD && r_hs)
      ram_byte_addr = next_addr(addr_reg, len_reg, burst_reg);
  end

  assign offset    = ram_byte_addr - BASE_ADDR;
  assign ram_index = offset[3+AW-1:3];
  assign unused_offset_bits = ^{offset[2:0], offset[31:3+AW]};

`ifdef AXI_MEM_RANGE_CHECK_EN
  // Addresses below BASE_ADDR wrap to a large offset and fail this test too
  assign beat_in_range = (offset[31:3+AW] == '0);
`else
  assign beat_in_range = 1'b1;
`endif

  assign ram_we = (w_hs && beat_in_range) ? wstrb : 8'h00;

  axi_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .addr  (ram_index),
    .we    (ram_we),
    .wdata (wdata),
    .rdata (ram_q)
  );

  // Next-state, arbitration and per-beat bookkeeping
  always_comb begin
    state_next   = state_reg;
    rr_pref_next = rr_pref_reg;
    arready_next = arready_reg;
    awready_next = awready_reg;
    addr_next    = addr_reg;
    id_next      = id_reg;
    len_next     = len_reg;
    beat_next    = beat_reg;
    burst_next   = burst_reg;
    err_next     = err_reg;
    rvalid_next  = rvalid_reg;
    rlast_next   = rlast_reg;
    rerr_next    = rerr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (ar_hs) begin
          arready_next = 1'b0;
          state_next   = ST_RD;
          addr_next    = araddr;
          id_next      = arid;
          len_next     = arlen;
          burst_next   = arburst;
          beat_next    = 8'd0;
          rvalid_next  = 1'b1;
          rlast_next   = (arlen == 8'd0);
          rerr_next    = !beat_in_range;
        end else if (aw_hs) begin
          awready_next = 1'b0;
          state_next   = ST_WR;
          addr_next    = awaddr;
          id_next      = awid;
          len_next     = awlen;
          burst_next   = awburst;
          beat_next    = 8'd0;
          err_next     = 1'b0;
        end else if (!arready_reg && !awready_reg) begin
          if (arvalid && awvalid) begin
            arready_next = !rr_pref_reg;
            awready_next = rr_pref_reg;
            rr_pref_next = !rr_pref_reg;
          end else if (arvalid) begin
            arready_next = 1'b1;
          end else if (awvalid) begin
            awready_next = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (r_hs) begin
          if (rlast_reg) begin
            state_next  = ST_IDLE;
            rvalid_next = 1'b0;
            rlast_next  = 1'b0;
            rerr_next   = 1'b0;
          end else begin
            beat_next  = beat_reg + 8'd1;
            addr_next  = next_addr(addr_reg, len_reg, burst_reg);
            rlast_next = ((beat_reg + 8'd1) == len_reg);
            rerr_next  = !beat_in_range;
          end
        end
      end
      ST_WR: begin
        if (w_hs) begin
          if ((wlast != (beat_reg == len_reg)) || !beat_in_range)
            err_next = 1'b1;
          beat_next = beat_reg + 8'd1;
          addr_next = next_addr(addr_reg, len_reg, burst_reg);
          if (beat_reg == len_reg)
            state_next = ST_WB;
        end
      end
      ST_WB: begin
        if (bready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      rr_pref_reg <= 1'b0;
      arready_reg <= 1'b0;
      awready_reg <= 1'b0;
      addr_reg    <= '0;
      id_reg      <= '0;
      len_reg     <= '0;
      beat_reg    <= '0;
      burst_reg   <= '0;
      err_reg     <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rerr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_pref_reg <= rr_pref_next;
      arready_reg <= arready_next;
      awready_reg <= awready_next;
      addr_reg    <= addr_next;
      id_reg      <= id_next;
      len_reg     <= len_next;
      beat_reg    <= beat_next;
      burst_reg   <= burst_next;
      err_reg     <= err_next;
      rvalid_reg  <= rvalid_next;
      rlast_reg   <= rlast_next;
      rerr_reg    <= rerr_next;
    end
  end

  assign arready = arready_reg;
  assign awready = awready_reg;
  assign wready  = (state_reg == ST_WR);
  assign bvalid  = (state_reg == ST_WB);
  assign bresp   = (state_reg == ST_WB && err_reg) ? RESP_SLVERR : RESP_OKAY;
  assign bid     = id_reg;
  assign rvalid  = rvalid_reg;
  assign rlast   = rlast_reg;
  assign rresp   = rerr_reg ? RESP_SLVERR : RESP_OKAY;
  assign rid     = id_reg;
  // RAM output is masked so rdata is 0 outside a beat and on suppressed beats
  assign rdata   = (rvalid_reg && !rerr_reg) ? ram_q : 64'd0;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected R/B responses,
// a monitor pops and compares them whenever the DUT completes a handshake.
module tb_axi_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  always #5 clk = ~clk;

  axi_mem_slave dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic exp_r(input logic [63:0] d, input logic l, input logic [3:0] id, input logic [1:0] resp);
    rq.push_back('{data: d, resp: resp, last: l, id: id});
  endtask

  task automatic exp_b(input logic [1:0] resp, input logic [3:0] id);
    bq.push_back('{resp: resp, id: id});
  endtask

  // Monitor: scoreboard pops plus stability check during read backpressure
  logic [66:0] hold_val;
  logic        hold_valid = 1'b0;
  always @(negedge clk) begin
    r_exp_t re;
    b_exp_t be;
    if (!reset) begin
      hold_valid = 1'b0;
    end else begin
      if (rvalid && !rready) begin
        if (hold_valid) chk("r_hold", {rdata, rresp, rlast}, hold_val);
        else begin
          hold_val   = {rdata, rresp, rlast};
          hold_valid = 1'b1;
        end
      end else begin
        hold_valid = 1'b0;
      end
      if (rvalid && rready) begin
        $display("R id=%0h data=%h resp=%0d last=%0d", rid, rdata, rresp, rlast);
        if (rq.size() == 0) begin
          checks++;
          $display("FAIL r_unexpected: beat id=%0h data=%h, required none", rid, rdata);
        end else begin
          re = rq.pop_front();
          chk("r_beat", {rdata, rresp, rlast, rid}, re);
        end
      end
      if (bvalid && bready) begin
        $display("B id=%0h resp=%0d", bid, bresp);
        if (bq.size() == 0) begin
          checks++;
          $display("FAIL b_unexpected: response id=%0h, required none", bid);
        end else begin
          be = bq.pop_front();
          chk("b_resp", {bresp, bid}, be);
        end
      end
    end
  end

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b, input logic [3:0] id);
    araddr = a; arlen = len; arburst = b; arid = id; arvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1;
        arvalid = 1'b0;
        return;
      end
    end
    checks++;
    $display("FAIL ar_timeout: arready not seen, required within 300 cycles");
    arvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b, input logic [3:0] id);
    awaddr = a; awlen = len; awburst = b; awid = id; awvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk); #1;
        awvalid = 1'b0;
        return;
      end
    end
    checks++;
    $display("FAIL aw_timeout: awready not seen, required within 300 cycles");
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk); #1;
        wvalid = 1'b0;
        return;
      end
    end
    checks++;
    $display("FAIL w_timeout: wready not seen, required within 300 cycles");
    wvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (rq.size() != 0 || bq.size() != 0); i++)
      @(negedge clk);
    if (rq.size() != 0 || bq.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d R and %0d B responses outstanding, required 0", rq.size(), bq.size());
      rq.delete();
      bq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Both address channels raised in the same cycle; record which is taken first
  task automatic conflict(input logic [31:0] ra, input logic [3:0] rid_i, input logic [63:0] rd_exp,
                          input logic [31:0] wa, input logic [3:0] wid_i, input logic [63:0] wd,
                          input logic read_first);
    logic [1:0] first;
    first = 2'd0;
    exp_r(rd_exp, 1'b1, rid_i, 2'b00);
    exp_b(2'b00, wid_i);
    araddr = ra; arlen = 8'd0; arburst = 2'b01; arid = rid_i;
    awaddr = wa; awlen = 8'd0; awburst = 2'b01; awid = wid_i;
    arvalid = 1'b1; awvalid = 1'b1;
    for (int i = 0; i < 300 && (arvalid || awvalid); i++) begin
      @(negedge clk);
      if (arready && arvalid) begin
        if (first == 2'd0) first = 2'd1;
        @(posedge clk); #1;
        arvalid = 1'b0;
      end else if (awready && awvalid) begin
        if (first == 2'd0) first = 2'd2;
        @(posedge clk); #1;
        awvalid = 1'b0;
        do_w(wd, 8'hFF, 1'b1);
      end
    end
    arvalid = 1'b0;
    awvalid = 1'b0;
    chk("arb_first", first, read_first ? 2'd1 : 2'd2);
    drain();
  endtask

  logic [63:0] wrap_exp [4];
  int n;

  initial begin
    reset = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 1'b1;
    wrap_exp[0] = 64'h44; wrap_exp[1] = 64'h11; wrap_exp[2] = 64'h22; wrap_exp[3] = 64'h33;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {arready, awready, rvalid, rlast, wready, bvalid, rdata, rresp, rid, bresp, bid}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // INCR write of four beats then read back
    exp_b(2'b00, 4'd1);
    do_aw(32'h8000_0000, 8'd3, 2'b01, 4'd1);
    for (int i = 0; i < 4; i++) do_w(64'h11 * (i + 1), 8'hFF, i == 3);
    for (int i = 0; i < 4; i++) exp_r(64'h11 * (i + 1), i == 3, 4'd2, 2'b00);
    do_ar(32'h8000_0000, 8'd3, 2'b01, 4'd2);
    drain();

    // WRAP read starting at word 3
    for (int i = 0; i < 4; i++) exp_r(wrap_exp[i], i == 3, 4'd3, 2'b00);
    do_ar(32'h8000_0018, 8'd3, 2'b10, 4'd3);
    drain();

    // Backpressure after the second beat
    for (int i = 0; i < 4; i++) exp_r(64'h11 * (i + 1), i == 3, 4'd4, 2'b00);
    do_ar(32'h8000_0000, 8'd3, 2'b01, 4'd4);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (rvalid && rready) n++;
    end
    if (n < 2) begin
      checks++;
      $display("FAIL bp_beats: %0d beats seen, required 2", n);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rready = 1'b1;
    drain();

    // Byte strobes: lower four bytes over all-ones
    exp_b(2'b00, 4'd5);
    do_aw(32'h8000_0040, 8'd0, 2'b01, 4'd5);
    do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    exp_b(2'b00, 4'd6);
    do_aw(32'h8000_0040, 8'd0, 2'b01, 4'd6);
    do_w(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1);
    exp_r(64'hFFFF_FFFF_89AB_CDEF, 1'b1, 4'd7, 2'b00);
    do_ar(32'h8000_0040, 8'd0, 2'b01, 4'd7);
    drain();

    // Early wlast: all four beats still consumed, SLVERR
    exp_b(2'b10, 4'd8);
    do_aw(32'h8000_0080, 8'd3, 2'b01, 4'd8);
    for (int i = 0; i < 4; i++) do_w(64'hC0 + i, 8'hFF, i == 1);
    for (int i = 0; i < 4; i++) exp_r(64'hC0 + i, i == 3, 4'd9, 2'b00);
    do_ar(32'h8000_0080, 8'd3, 2'b01, 4'd9);
    drain();

    // Two back-to-back conflicts alternate, read first
    conflict(32'h8000_0000, 4'hA, 64'h11, 32'h8000_00C0, 4'hB, 64'hA1, 1'b1);
    conflict(32'h8000_00C0, 4'hC, 64'hA1, 32'h8000_00C8, 4'hD, 64'hB2, 1'b0);

`ifdef AXI_MEM_RANGE_CHECK_EN
    exp_b(2'b10, 4'd1);
    do_aw(32'h8000_2000, 8'd0, 2'b01, 4'd1);
    do_w(64'h55, 8'hFF, 1'b1);
    exp_r(64'd0, 1'b1, 4'd2, 2'b10);
    do_ar(32'h7FFF_FFF8, 8'd0, 2'b01, 4'd2);
`else
    exp_b(2'b00, 4'd1);
    do_aw(32'h8000_2028, 8'd0, 2'b01, 4'd1);
    do_w(64'h55, 8'hFF, 1'b1);
    exp_r(64'h55, 1'b1, 4'd2, 2'b00);
    do_ar(32'h8000_0028, 8'd0, 2'b01, 4'd2);
`endif
    exp_r(64'h11, 1'b1, 4'd3, 2'b00);
    do_ar(32'h8000_0000, 8'd0, 2'b01, 4'd3);
    drain();

    // Asynchronous reset in the middle of a stalled read burst
    rready = 1'b0;
    do_ar(32'h8000_0000, 8'd7, 2'b01, 4'd4);
    @(negedge clk);
    chk("rvalid_before_reset", rvalid, 1'b1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("reset_async", {rvalid, rlast, bvalid, wready, arready, awready, rdata}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rready = 1'b1;
    exp_r(64'h11, 1'b1, 4'd5, 2'b00);
    do_ar(32'h8000_0000, 8'd0, 2'b01, 4'd5);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
